// File: rtl/fetch_controller_if.sv
// Fetch-side bundle: instruction memory port, decode handshake and execute controls.
interface fetch_controller_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) ();
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              halt;
    logic              busy;
    logic              wrapped;

    modport master (
        input  start, imem_data, instr_ready, jump, jump_target, halt,
        output imem_addr, instr, instr_pc, instr_valid, busy, wrapped
    );

    modport slave (
        output start, imem_data, instr_ready, jump, jump_target, halt,
        input  imem_addr, instr, instr_pc, instr_valid, busy, wrapped
    );
endinterface

// File: rtl/fetch_controller.sv
// Program counter and one-deep fetch register feeding decode over valid/ready,
// with jump redirect, permanent halt and a sticky PC wrap flag.
module fetch_controller #(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                n_reset,
    fetch_controller_if.master  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_MAX = {ADDR_W{1'b1}};

    state_t              r_state,       w_state_nxt;
    logic [ADDR_W-1:0]   r_pc,          w_pc_nxt;
    logic [DATA_W-1:0]   r_instr,       w_instr_nxt;
    logic [ADDR_W-1:0]   r_instr_pc,    w_instr_pc_nxt;
    logic                r_instr_valid, w_instr_valid_nxt;
    logic                r_wrapped,     w_wrapped_nxt;
    logic                w_capture;

    // Capture only when the output slot is empty or being drained this edge.
    assign w_capture = (r_state == ST_RUN) && !bus.halt && !bus.jump &&
                       (!r_instr_valid || bus.instr_ready);

    // Next-state and datapath decode; halt beats jump beats capture.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_instr_nxt       = r_instr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_valid_nxt = r_instr_valid;
        w_wrapped_nxt     = r_wrapped;

        case (r_state)
            ST_IDLE: begin
                if (bus.halt) begin
                    w_state_nxt = ST_HALTED;
                end else if (bus.jump) begin
                    w_pc_nxt = bus.jump_target;
                end else if (bus.start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.halt) begin
                    w_state_nxt       = ST_HALTED;
                    w_instr_valid_nxt = 1'b0;
                end else if (bus.jump) begin
                    w_pc_nxt          = bus.jump_target;
                    w_instr_valid_nxt = 1'b0;
                end else if (w_capture) begin
                    w_instr_nxt       = bus.imem_data;
                    w_instr_pc_nxt    = r_pc;
                    w_instr_valid_nxt = 1'b1;
                    w_pc_nxt          = r_pc + ADDR_W'(1);
                    if (r_pc == PC_MAX) begin
                        w_wrapped_nxt = 1'b1;
                    end
                end
            end
            ST_HALTED: begin
                w_instr_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt       = ST_IDLE;
                w_instr_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= ADDR_W'(RESET_PC);
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_wrapped     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_wrapped     <= w_wrapped_nxt;
        end
    end

    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
    assign bus.busy        = (r_state == ST_RUN);
    assign bus.wrapped     = r_wrapped;
endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller against a {~addr, addr} instruction memory.
module tb_fetch_controller;
    logic clk;
    logic n_reset;
    int   total;
    int   bad;
    logic [18:0] obs;
    logic [18:0] e;

    fetch_controller_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    fetch_controller #(.ADDR_W(4), .DATA_W(8), .RESET_PC(0)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    assign bus.imem_data = {~bus.imem_addr, bus.imem_addr};
    assign obs = {bus.busy, bus.wrapped, bus.instr_valid, bus.instr, bus.instr_pc, bus.imem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packs an expected observation: busy, wrapped, valid, instr, instr_pc, imem_addr.
    function automatic logic [18:0] pk(input logic b, input logic w, input logic v,
                                       input logic [7:0] i, input logic [3:0] p,
                                       input logic [3:0] a);
        return {b, w, v, i, p, a};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.instr_ready = 1'b0; bus.jump = 1'b0;
        bus.jump_target = 4'h0; bus.halt = 1'b0;
    endtask

    task automatic reset_and_start();
        idle_inputs();
        n_reset = 1'b0;
        step(); step();
        n_reset = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        n_reset = 1'b0;
        step(); step();
        e = pk(0, 0, 0, 8'h00, 4'h0, 4'h0); total++;
        if (obs !== e) begin bad++; $display("FAIL reset got=%h want=%h", obs, e); end
        n_reset = 1'b1;
        step();
        e = pk(0, 0, 0, 8'h00, 4'h0, 4'h0); total++;
        if (obs !== e) begin bad++; $display("FAIL idle_no_start got=%h want=%h", obs, e); end
    endtask

    task automatic test_stream();
        reset_and_start();
        e = pk(1, 0, 0, 8'h00, 4'h0, 4'h0); total++;
        if (obs !== e) begin bad++; $display("FAIL start_edge got=%h want=%h", obs, e); end
        bus.instr_ready = 1'b1;
        step();
        e = pk(1, 0, 1, 8'hF0, 4'h0, 4'h1); total++;
        if (obs !== e) begin bad++; $display("FAIL stream0 got=%h want=%h", obs, e); end
        step();
        e = pk(1, 0, 1, 8'hE1, 4'h1, 4'h2); total++;
        if (obs !== e) begin bad++; $display("FAIL stream1 got=%h want=%h", obs, e); end
        step();
        e = pk(1, 0, 1, 8'hD2, 4'h2, 4'h3); total++;
        if (obs !== e) begin bad++; $display("FAIL stream2 got=%h want=%h", obs, e); end
    endtask

    task automatic test_hold();
        reset_and_start();
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            e = pk(1, 0, 1, 8'hF0, 4'h0, 4'h1); total++;
            if (obs !== e) begin bad++; $display("FAIL hold%0d got=%h want=%h", k, obs, e); end
        end
        bus.instr_ready = 1'b1;
        step();
        e = pk(1, 0, 1, 8'hE1, 4'h1, 4'h2); total++;
        if (obs !== e) begin bad++; $display("FAIL hold_release got=%h want=%h", obs, e); end
    endtask

    // Continues from (E1,1) valid with instr_ready=1.
    task automatic test_jump();
        bus.jump = 1'b1; bus.jump_target = 4'hA;
        step();
        bus.jump = 1'b0;
        e = pk(1, 0, 0, 8'hE1, 4'h1, 4'hA); total++;
        if (obs !== e) begin bad++; $display("FAIL jump_flush got=%h want=%h", obs, e); end
        step();
        e = pk(1, 0, 1, 8'h5A, 4'hA, 4'hB); total++;
        if (obs !== e) begin bad++; $display("FAIL jump_target got=%h want=%h", obs, e); end
    endtask

    task automatic test_wrap();
        bus.jump = 1'b1; bus.jump_target = 4'hE;
        step();
        bus.jump = 1'b0;
        step();
        e = pk(1, 0, 1, 8'h1E, 4'hE, 4'hF); total++;
        if (obs !== e) begin bad++; $display("FAIL wrap_e got=%h want=%h", obs, e); end
        step();
        e = pk(1, 1, 1, 8'h0F, 4'hF, 4'h0); total++;
        if (obs !== e) begin bad++; $display("FAIL wrap_f got=%h want=%h", obs, e); end
        step();
        e = pk(1, 1, 1, 8'hF0, 4'h0, 4'h1); total++;
        if (obs !== e) begin bad++; $display("FAIL wrap_0 got=%h want=%h", obs, e); end
        bus.jump = 1'b1; bus.jump_target = 4'h0;
        step();
        bus.jump = 1'b0;
        e = pk(1, 1, 0, 8'hF0, 4'h0, 4'h0); total++;
        if (obs !== e) begin bad++; $display("FAIL wrap_sticky got=%h want=%h", obs, e); end
        step();
    endtask

    // Continues in RUN with (F0,0) valid and imem_addr=1.
    task automatic test_halt_jump();
        bus.halt = 1'b1; bus.jump = 1'b1; bus.jump_target = 4'h3;
        step();
        bus.halt = 1'b0; bus.jump = 1'b0;
        e = pk(0, 1, 0, 8'hF0, 4'h0, 4'h1); total++;
        if (obs !== e) begin bad++; $display("FAIL halt got=%h want=%h", obs, e); end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.jump = 1'b1; bus.jump_target = 4'h7;
        step();
        bus.jump = 1'b0;
        step();
        e = pk(0, 1, 0, 8'hF0, 4'h0, 4'h1); total++;
        if (obs !== e) begin bad++; $display("FAIL halt_frozen got=%h want=%h", obs, e); end
    endtask

    task automatic test_idle_jump();
        idle_inputs();
        n_reset = 1'b0;
        step();
        n_reset = 1'b1;
        bus.jump = 1'b1; bus.jump_target = 4'h9;
        step();
        bus.jump = 1'b0;
        e = pk(0, 0, 0, 8'h00, 4'h0, 4'h9); total++;
        if (obs !== e) begin bad++; $display("FAIL idle_jump got=%h want=%h", obs, e); end
        bus.start = 1'b1; bus.instr_ready = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        e = pk(1, 0, 1, 8'h69, 4'h9, 4'hA); total++;
        if (obs !== e) begin bad++; $display("FAIL idle_jump_fetch got=%h want=%h", obs, e); end
    endtask

    task automatic test_async_reset();
        reset_and_start();
        bus.instr_ready = 1'b1;
        bus.jump = 1'b1; bus.jump_target = 4'hE;
        step();
        bus.jump = 1'b0;
        step(); step();
        bus.jump = 1'b1; bus.jump_target = 4'h5;
        step();
        bus.jump = 1'b0;
        e = pk(1, 1, 0, 8'h0F, 4'hF, 4'h5); total++;
        if (obs !== e) begin bad++; $display("FAIL pre_reset got=%h want=%h", obs, e); end
        #2;
        n_reset = 1'b0;
        #1;
        e = pk(0, 0, 0, 8'h00, 4'h0, 4'h0); total++;
        if (obs !== e) begin bad++; $display("FAIL async_reset got=%h want=%h", obs, e); end
        #2;
        n_reset = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        e = pk(1, 0, 1, 8'hF0, 4'h0, 4'h1); total++;
        if (obs !== e) begin bad++; $display("FAIL resume got=%h want=%h", obs, e); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        n_reset = 1'b0;
        idle_inputs();
        test_reset();
        test_stream();
        test_hold();
        test_jump();
        test_wrap();
        test_halt_jump();
        test_idle_jump();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
